// File: rtl/store_buffer.sv
// store_buffer
// Post-commit store buffer between the memory stage and the DCache write port.
// It accepts byte, halfword, word and unaligned-word (SWL/SWR) stores. Each store
// becomes a word address, byte enables and lane-aligned data. Entries drain to the
// cache in strict FIFO order.
//
// Ports:
//   clk, resetn             - clock and asynchronous active-low reset
//   st_valid/st_ready       - store request handshake from the memory stage
//   st_op/st_addr/st_rt_value - store kind, byte address and raw rt value
//   st_err                  - one-cycle pulse after a discarded (illegal) store
//   wr_req/wr_ok            - head entry offered to / taken by the DCache
//   wr_addr/wr_wstrb/wr_wdata - head entry word address, byte enables, data
//   ld_addr/ld_conflict     - load word address check against pending stores
//   sb_empty                - no store pending
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_rt_value,
  output logic        st_err,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [3:0]  wr_wstrb,
  output logic [31:0] wr_wdata,
  input  logic        wr_ok,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        sb_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic        legal;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dec_t;

  // Translate a store into byte enables and lane-aligned data; illegal when misaligned or reserved.
  function automatic dec_t decode_store(input logic [2:0] op, input logic [1:0] a,
                                        input logic [31:0] rt);
    dec_t d;
    d.legal = 1'b0;
    d.wstrb = 4'b0000;
    d.wdata = 32'h0000_0000;
    case (op)
      3'd0: begin
        d.legal = 1'b1;
        d.wstrb = 4'b0001 << a;
        d.wdata = {4{rt[7:0]}};
      end
      3'd1: begin
        d.legal = ~a[0];
        d.wstrb = a[1] ? 4'b1100 : 4'b0011;
        d.wdata = {2{rt[15:0]}};
      end
      3'd2: begin
        d.legal = (a == 2'd0);
        d.wstrb = 4'b1111;
        d.wdata = rt;
      end
      3'd3: begin
        d.legal = 1'b1;
        case (a)
          2'd0:    begin d.wstrb = 4'b0001; d.wdata = {24'h00_0000, rt[31:24]}; end
          2'd1:    begin d.wstrb = 4'b0011; d.wdata = {16'h0000, rt[31:16]}; end
          2'd2:    begin d.wstrb = 4'b0111; d.wdata = {8'h00, rt[31:8]}; end
          default: begin d.wstrb = 4'b1111; d.wdata = rt; end
        endcase
      end
      3'd4: begin
        d.legal = 1'b1;
        case (a)
          2'd0:    begin d.wstrb = 4'b1111; d.wdata = rt; end
          2'd1:    begin d.wstrb = 4'b1110; d.wdata = {rt[23:0], 8'h00}; end
          2'd2:    begin d.wstrb = 4'b1100; d.wdata = {rt[15:0], 16'h0000}; end
          default: begin d.wstrb = 4'b1000; d.wdata = {rt[7:0], 24'h00_0000}; end
        endcase
      end
      default: begin
        d.legal = 1'b0;
      end
    endcase
    return d;
  endfunction

  logic [29:0]   addr_mem_r [DEPTH];
  logic [3:0]    strb_mem_r [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          st_err_r;

  dec_t          dec_s;
  logic          st_ready_s;
  logic          wr_req_s;
  logic          push_s;
  logic          pop_s;
  logic          conflict_s;
  logic [AW-1:0] off_s;
  logic [1:0]    ld_addr_unused_s;

  assign ld_addr_unused_s = ld_addr[1:0];

  // Handshake and enqueue/dequeue qualification; an illegal store completes but is not pushed.
  always_comb begin
    dec_s      = decode_store(st_op, st_addr[1:0], st_rt_value);
    st_ready_s = (count_r < CNT_FULL);
    wr_req_s   = (count_r != {CW{1'b0}});
    push_s     = st_valid && st_ready_s && dec_s.legal;
    pop_s      = wr_req_s && wr_ok;
  end

  // Load-hazard detection over live entries plus the store being accepted this cycle.
  always_comb begin
    conflict_s = 1'b0;
    off_s      = {AW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is live when its distance from head is below the occupancy.
      off_s = AW'(i) - head_r;
      if (({1'b0, off_s} < count_r) && (addr_mem_r[i] == ld_addr[31:2])) begin
        conflict_s = 1'b1;
      end else begin
        conflict_s = conflict_s;
      end
    end
    if (push_s && (st_addr[31:2] == ld_addr[31:2])) begin
      conflict_s = 1'b1;
    end else begin
      conflict_s = conflict_s;
    end
  end

  // Entry payload storage; deliberately not reset since occupancy is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[tail_r] <= st_addr[31:2];
      strb_mem_r[tail_r] <= dec_s.wstrb;
      data_mem_r[tail_r] <= dec_s.wdata;
    end
  end

  // Pointer, occupancy and error-pulse state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_r   <= {AW{1'b0}};
      tail_r   <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      st_err_r <= 1'b0;
    end else begin
      st_err_r <= st_valid && st_ready_s && !dec_s.legal;
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign st_ready    = st_ready_s;
  assign st_err      = st_err_r;
  assign wr_req      = wr_req_s;
  assign wr_addr     = {addr_mem_r[head_r], 2'b00};
  assign wr_wstrb    = strb_mem_r[head_r];
  assign wr_wdata    = data_mem_r[head_r];
  assign ld_conflict = conflict_s;
  assign sb_empty    = !wr_req_s;

endmodule
